// File: rtl/sr_prbs_checker.sv
// PRBS7 (x^7+x^6+1) checker for the shift-register tail bit: self-seeds, then counts mismatches and tracks lock.
// Optional SR_CHK_BITCNT_EN adds a 32-bit count of compared samples on bit_cnt.
module sr_prbs_checker #(
  parameter int ERR_W       = 16,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sample_en,
  input  logic             sr_bit,
  input  logic             clr,
  output logic             locked,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_cnt,
  output logic             sat
`ifdef SR_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  localparam int WC_W = $clog2(WINDOW);
  localparam int WE_W = $clog2(LOSS_THRESH + 1);
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [WE_W-1:0] THRESH   = WE_W'(LOSS_THRESH);

  typedef enum logic [1:0] {IDLE, SEED, LOCKED} state_t;

  state_t          state;
  logic [6:0]      lfsr;
  logic [2:0]      fill;
  logic [WC_W-1:0] win_cnt;
  logic [WE_W-1:0] win_err;

  logic             exp_bit;
  logic [6:0]       seed_next;
  logic             cmp_en;
  logic             mismatch;
  logic [WE_W-1:0]  win_err_inc;
  logic [ERR_W-1:0] err_cnt_next;

  assign exp_bit     = lfsr[6] ^ lfsr[5];
  assign seed_next   = {lfsr[5:0], sr_bit};
  assign cmp_en      = enable && sample_en && (state == LOCKED);
  assign mismatch    = cmp_en && (sr_bit != exp_bit);
  assign win_err_inc = win_err + WE_W'(1);

  // clr wins over a same-cycle mismatch; the counter sticks at all-ones
  always_comb begin
    err_cnt_next = err_cnt;
    if (clr)
      err_cnt_next = '0;
    else if (mismatch && (err_cnt != '1))
      err_cnt_next = err_cnt + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= '0;
      fill     <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
      locked   <= 1'b0;
      err_flag <= 1'b0;
      err_cnt  <= '0;
      sat      <= 1'b0;
    end else begin
      err_cnt  <= err_cnt_next;
      sat      <= &err_cnt_next;
      err_flag <= mismatch;
      if (!enable) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= SEED;
            fill    <= '0;
            win_cnt <= '0;
            win_err <= '0;
          end
          SEED: begin
            if (sample_en) begin
              lfsr <= seed_next;
              if (fill == 3'd6) begin
                fill <= '0;
                // an all-zero seed would lock the LFSR up, so gather 7 more bits
                if (seed_next != 7'd0) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                fill <= fill + 3'd1;
              end
            end
          end
          LOCKED: begin
            if (sample_en) begin
              lfsr <= {lfsr[5:0], exp_bit};
              if (mismatch && (win_err_inc == THRESH)) begin
                state   <= SEED;
                locked  <= 1'b0;
                fill    <= '0;
                win_cnt <= '0;
                win_err <= '0;
              end else if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                win_err <= '0;
              end else begin
                win_cnt <= win_cnt + WC_W'(1);
                if (mismatch)
                  win_err <= win_err_inc;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SR_CHK_BITCNT_EN
  always_ff @(posedge clk) begin
    if (rst || clr)
      bit_cnt <= '0;
    else if (cmp_en)
      bit_cnt <= bit_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sr_prbs_checker.sv
// Directed bench for sr_prbs_checker: a default instance plus an ERR_W=3 instance driven by the same stimulus.
module tb_sr_prbs_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, enable = 1'b0, sample_en = 1'b0, sr_bit = 1'b0, clr = 1'b0;
    logic locked, err_flag, sat;
    logic [15:0] err_cnt;
    logic locked3, err_flag3, sat3;
    logic [2:0] err_cnt3;
`ifdef SR_CHK_BITCNT_EN
    logic [31:0] bit_cnt, bit_cnt3;
`endif

    sr_prbs_checker dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_en(sample_en), .sr_bit(sr_bit), .clr(clr),
        .locked(locked), .err_flag(err_flag), .err_cnt(err_cnt), .sat(sat)
`ifdef SR_CHK_BITCNT_EN
        , .bit_cnt(bit_cnt)
`endif
    );

    sr_prbs_checker #(.ERR_W(3)) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .sample_en(sample_en), .sr_bit(sr_bit), .clr(clr),
        .locked(locked3), .err_flag(err_flag3), .err_cnt(err_cnt3), .sat(sat3)
`ifdef SR_CHK_BITCNT_EN
        , .bit_cnt(bit_cnt3)
`endif
    );

    int total = 0, bad = 0;
    int nflag;
    logic [6:0] g;
    logic last_flag, last_lk, lk_ever, lk_drop, b;
    logic done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // reference PRBS7 generator
    task automatic gen(output logic ob);
        ob = g[6] ^ g[5];
        g  = {g[5:0], ob};
    endtask

    // one sample strobe followed by one idle clock; outputs captured 1 ns after the sampling edge
    task automatic step(input logic ib);
        sample_en = 1'b1;
        sr_bit    = ib;
        @(posedge clk); #1;
        sample_en = 1'b0;
        clr       = 1'b0;
        last_flag = err_flag;
        last_lk   = locked;
        nflag     += int'(err_flag);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; sample_en = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        nflag = 0;
    endtask

    // IDLE -> SEED, then feed the 7 seed bits of the stream starting at 7'h7F
    task automatic do_seed(input string tag);
        enable = 1'b1;
        @(posedge clk); #1;
        g = 7'h7F;
        for (int i = 0; i < 7; i++) begin
            gen(b);
            step(b);
            if (i == 5) check({tag, "_unlocked_6th"}, last_lk, 1'b0);
        end
        check({tag, "_locked_7th"}, last_lk, 1'b1);
    endtask

    initial begin
        #1_000_000;
        if (!done) begin
            total++;
            bad++;
            $error("FAIL timeout: stimulus did not complete");
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        // reset state
        do_reset();
        check("rst_locked", locked, 1'b0);
        check("rst_err_flag", err_flag, 1'b0);
        check("rst_err_cnt", err_cnt, 16'd0);
        check("rst_sat", sat, 1'b0);

        // T1: clean stream, 200 compared bits
        do_seed("t1");
        lk_drop = 1'b0;
        for (int k = 0; k < 200; k++) begin
            gen(b); step(b);
            if (!last_lk) lk_drop = 1'b1;
        end
        check("t1_flags", nflag, 0);
        check("t1_err_cnt", err_cnt, 16'd0);
        check("t1_lock_held", lk_drop, 1'b0);
`ifdef SR_CHK_BITCNT_EN
        check("t1_bit_cnt", bit_cnt, 32'd200);
`endif

        // T6: reset while locked with enable held high
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_locked", locked, 1'b0);
        check("t6_err_flag", err_flag, 1'b0);
        check("t6_err_cnt", err_cnt, 16'd0);
        check("t6_sat", sat, 1'b0);
`ifdef SR_CHK_BITCNT_EN
        check("t6_bit_cnt", bit_cnt, 32'd0);
`endif
        nflag = 0;
        do_seed("t6");

        // T2: single inverted bit at compared sample #50
        do_reset();
        do_seed("t2");
        lk_drop = 1'b0;
        for (int k = 0; k < 100; k++) begin
            gen(b);
            step((k == 49) ? ~b : b);
            if (k == 49) check("t2_flag_at_50", last_flag, 1'b1);
            if (!last_lk) lk_drop = 1'b1;
        end
        check("t2_flags", nflag, 1);
        check("t2_err_cnt", err_cnt, 16'd1);
        check("t2_lock_held", lk_drop, 1'b0);

        // disable: back to IDLE, error count held
        enable = 1'b0;
        @(posedge clk); #1;
        check("dis_locked", locked, 1'b0);
        check("dis_err_cnt_held", err_cnt, 16'd1);

        // T3: 8 errors inside one window force a relock
        do_reset();
        do_seed("t3");
        for (int k = 0; k < 25; k++) begin
            gen(b);
            step((k >= 10 && k % 2 == 0) ? ~b : b);
            if (k == 22) check("t3_locked_after_7", last_lk, 1'b1);
        end
        check("t3_flag_8th", last_flag, 1'b1);
        check("t3_lost_lock", last_lk, 1'b0);
        for (int k = 0; k < 7; k++) begin
            gen(b); step(b);
            if (k == 5) check("t3_relock_6th", last_lk, 1'b0);
        end
        check("t3_relock_7th", last_lk, 1'b1);
        for (int k = 0; k < 30; k++) begin
            gen(b); step(b);
        end
        check("t3_flags", nflag, 8);
        check("t3_err_cnt", err_cnt, 16'd8);
        check("t3_locked_end", locked, 1'b1);

        // T4: constant zero never seeds
        do_reset();
        enable = 1'b1;
        @(posedge clk); #1;
        lk_ever = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step(1'b0);
            if (last_lk) lk_ever = 1'b1;
        end
        check("t4_never_locked", lk_ever, 1'b0);
        check("t4_err_cnt", err_cnt, 16'd0);

        // T5: one error per 64-sample window for 10 windows
        do_reset();
        do_seed("t5");
        for (int k = 0; k < 640; k++) begin
            gen(b);
            step((k % 64 == 5) ? ~b : b);
        end
        check("t5_err_cnt", err_cnt, 16'd10);
        check("t5_sat", sat, 1'b0);
        check("t5_locked", locked, 1'b1);
        check("t5_err_cnt3", err_cnt3, 3'd7);
        check("t5_sat3", sat3, 1'b1);
        check("t5_locked3", locked3, 1'b1);
        // clr together with a mismatch: flag pulses, count cleared
        clr = 1'b1;
        gen(b);
        step(~b);
        check("t5_clr_flag", last_flag, 1'b1);
        check("t5_clr_err_cnt", err_cnt, 16'd0);
        check("t5_clr_sat", sat, 1'b0);
        check("t5_clr_err_cnt3", err_cnt3, 3'd0);
        check("t5_clr_sat3", sat3, 1'b0);
`ifdef SR_CHK_BITCNT_EN
        check("t5_clr_bit_cnt", bit_cnt, 32'd0);
`endif

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
